// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU operand stage.
//   alu_src_t : operand B source select
//   REG_IDX_W : register number width
//   XZR_IDX   : zero register, never a forwarding target
package alu_operand_pkg;

   typedef enum logic [1:0] {
      SRC_REG       = 2'd0,
      SRC_IMM       = 2'd1,
      SRC_IMM_SHIFT = 2'd2,
      SRC_ZERO      = 2'd3
   } alu_src_t;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding priority match for one source operand.
// Ports:
//   idx       : source register number
//   rf_data   : register-file read data, used when no forward matches
//   fwd_valid : per-source forward enable
//   fwd_idx   : per-source destination register, source 0 in the LSBs
//   fwd_data  : per-source result, source 0 in the LSBs
//   value     : resolved operand value
module fwd_select
   import alu_operand_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int N_FWD = 2
) (
   input  logic [REG_IDX_W-1:0]       idx,
   input  logic [WIDTH-1:0]           rf_data,
   input  logic [N_FWD-1:0]           fwd_valid,
   input  logic [REG_IDX_W*N_FWD-1:0] fwd_idx,
   input  logic [WIDTH*N_FWD-1:0]     fwd_data,
   output logic [WIDTH-1:0]           value
);

   // Walk from the oldest source down to source 0 so the youngest match is
   // the last assignment and therefore wins; no match leaves rf_data.
   always_comb begin
      value = rf_data;
      for (int k = N_FWD - 1; k >= 0; k--) begin
         if (fwd_valid[k] &&
             (fwd_idx[k*REG_IDX_W +: REG_IDX_W] == idx) &&
             (idx != XZR_IDX)) begin
            value = fwd_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: forwards rs1/rs2, selects operand B and
// holds the result in a valid/ready pipeline register.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : upstream handshake
//   read_data1/2, imm    : register-file data and pre-extended immediate
//   alu_src              : operand B select (alu_src_t)
//   rs1_idx, rs2_idx     : source register numbers
//   fwd_valid/idx/data   : forwarding sources, source 0 in the LSBs
//   out_valid / out_ready: downstream handshake
//   data1, data2         : operands A and B
//   store_data           : forwarded rs2 value regardless of alu_src
module alu_operand_stage
   import alu_operand_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int N_FWD     = 2,
   parameter int IMM_SHIFT = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           read_data1,
   input  logic [WIDTH-1:0]           read_data2,
   input  logic [WIDTH-1:0]           imm,
   input  logic [1:0]                 alu_src,
   input  logic [REG_IDX_W-1:0]       rs1_idx,
   input  logic [REG_IDX_W-1:0]       rs2_idx,
   input  logic [N_FWD-1:0]           fwd_valid,
   input  logic [REG_IDX_W*N_FWD-1:0] fwd_idx,
   input  logic [WIDTH*N_FWD-1:0]     fwd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           data1,
   output logic [WIDTH-1:0]           data2,
   output logic [WIDTH-1:0]           store_data
);

   logic [WIDTH-1:0] rs1_value;
   logic [WIDTH-1:0] rs2_value;
   logic [WIDTH-1:0] imm_shifted;
   logic [WIDTH-1:0] operand_b;
   logic             capture;
   alu_src_t         src_sel;

   fwd_select #(
      .WIDTH (WIDTH),
      .N_FWD (N_FWD)
   ) u_fwd_rs1 (
      .idx       (rs1_idx),
      .rf_data   (read_data1),
      .fwd_valid (fwd_valid),
      .fwd_idx   (fwd_idx),
      .fwd_data  (fwd_data),
      .value     (rs1_value)
   );

   fwd_select #(
      .WIDTH (WIDTH),
      .N_FWD (N_FWD)
   ) u_fwd_rs2 (
      .idx       (rs2_idx),
      .rf_data   (read_data2),
      .fwd_valid (fwd_valid),
      .fwd_idx   (fwd_idx),
      .fwd_data  (fwd_data),
      .value     (rs2_value)
   );

   // Bits shifted past the top are dropped.
   assign imm_shifted = imm << IMM_SHIFT;
   assign src_sel     = alu_src_t'(alu_src);

   always_comb begin
      operand_b = '0;
      case (src_sel)
         SRC_REG:       operand_b = rs2_value;
         SRC_IMM:       operand_b = imm;
         SRC_IMM_SHIFT: operand_b = imm_shifted;
         SRC_ZERO:      operand_b = '0;
         default:       operand_b = '0;
      endcase
   end

   // out_ready only reaches in_ready; data registers see it solely through
   // the capture enable, so no combinational path reaches the data outputs.
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         data1      <= '0;
         data2      <= '0;
         store_data <= '0;
      end else if (capture) begin
         out_valid  <= 1'b1;
         data1      <= rs1_value;
         data2      <= operand_b;
         store_data <= rs2_value;
      end else if (out_ready) begin
         // Bundle consumed with nothing new behind it; data holds.
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   localparam int WIDTH = 64;
   localparam int N_FWD = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   read_data1;
   logic [WIDTH-1:0]   read_data2;
   logic [WIDTH-1:0]   imm;
   logic [1:0]         alu_src;
   logic [4:0]         rs1_idx;
   logic [4:0]         rs2_idx;
   logic [N_FWD-1:0]   fwd_valid;
   logic [5*N_FWD-1:0] fwd_idx;
   logic [WIDTH*N_FWD-1:0] fwd_data;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   data1;
   logic [WIDTH-1:0]   data2;
   logic [WIDTH-1:0]   store_data;

   int n_checks = 0;
   int n_errors = 0;

   alu_operand_stage #(
      .WIDTH     (WIDTH),
      .N_FWD     (N_FWD),
      .IMM_SHIFT (12)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .imm        (imm),
      .alu_src    (alu_src),
      .rs1_idx    (rs1_idx),
      .rs2_idx    (rs2_idx),
      .fwd_valid  (fwd_valid),
      .fwd_idx    (fwd_idx),
      .fwd_data   (fwd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data1      (data1),
      .data2      (data2),
      .store_data (store_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample and drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] sd);
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
      chk({tag, ".data1"}, data1, d1);
      chk({tag, ".data2"}, data2, d2);
      chk({tag, ".store_data"}, store_data, sd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      read_data1 = '0; read_data2 = '0; imm = '0; alu_src = 2'd0;
      rs1_idx = 5'd1; rs2_idx = 5'd2;
      fwd_valid = '0; fwd_idx = '0; fwd_data = '0;
      step(); step();
      chk_out("reset", 1'b0, 64'h0, 64'h0, 64'h0);
      chk("reset.in_ready", {63'd0, in_ready}, 64'd1);
      reset = 1'b0;
      step();
      chk_out("idle", 1'b0, 64'h0, 64'h0, 64'h0);

      // Basic register path
      in_valid = 1'b1; alu_src = 2'd0; read_data1 = 64'd5; read_data2 = 64'd7;
      step();
      chk_out("basic", 1'b1, 64'd5, 64'd7, 64'd7);

      // Immediate modes, back to back
      alu_src = 2'd1; imm = 64'h10; read_data2 = 64'h99;
      step();
      chk_out("imm", 1'b1, 64'd5, 64'h10, 64'h99);
      alu_src = 2'd2; imm = 64'h3;
      step();
      chk("imm_shift", data2, 64'h3000);
      imm = 64'h0018_0000_0000_0001;
      step();
      chk("imm_shift_trunc", data2, 64'h8000_0000_0000_1000);
      alu_src = 2'd3;
      step();
      chk_out("zero", 1'b1, 64'd5, 64'h0, 64'h99);

      // Forward priority
      alu_src = 2'd0; rs1_idx = 5'd4; rs2_idx = 5'd4; read_data1 = 64'h11;
      fwd_valid = 2'b11; fwd_idx = {5'd4, 5'd4}; fwd_data = {64'hBB, 64'hAA};
      step();
      chk_out("fwd_both", 1'b1, 64'hAA, 64'hAA, 64'hAA);
      fwd_valid = 2'b10;
      step();
      chk_out("fwd_src1", 1'b1, 64'hBB, 64'hBB, 64'hBB);
      fwd_valid = 2'b00;
      step();
      chk_out("fwd_none", 1'b1, 64'h11, 64'h99, 64'h99);
      fwd_valid = 2'b01; fwd_idx = {5'd4, 5'd3}; rs2_idx = 5'd3; alu_src = 2'd1; imm = 64'h42;
      step();
      chk_out("fwd_store_imm", 1'b1, 64'h11, 64'h42, 64'hAA);

      // XZR is never forwarded
      alu_src = 2'd0; rs1_idx = 5'd31; rs2_idx = 5'd31; read_data1 = 64'h0; read_data2 = 64'h0;
      fwd_valid = 2'b11; fwd_idx = {5'd31, 5'd31}; fwd_data = {64'hEE, 64'hFF};
      step();
      chk_out("xzr", 1'b1, 64'h0, 64'h0, 64'h0);

      // Backpressure: capture bundle, then hold for 3 cycles
      rs1_idx = 5'd1; rs2_idx = 5'd2; fwd_valid = 2'b00;
      read_data1 = 64'h1234; read_data2 = 64'h5678; alu_src = 2'd0;
      step();
      chk_out("bp_capture", 1'b1, 64'h1234, 64'h5678, 64'h5678);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         read_data1 = 64'hA000 + 64'(i); read_data2 = 64'hB000 + 64'(i);
         alu_src = 2'(i); imm = 64'h77;
         rs1_idx = 5'd1; rs2_idx = 5'd2;
         fwd_valid = 2'b11; fwd_idx = {5'd2, 5'd1}; fwd_data = {64'hC0DE, 64'hBEEF};
         #1;
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         step();
         chk_out("bp_hold", 1'b1, 64'h1234, 64'h5678, 64'h5678);
      end

      // Release with a new bundle waiting: replaces on the next edge
      fwd_valid = 2'b00; read_data1 = 64'hCAFE; read_data2 = 64'hF00D; alu_src = 2'd0;
      out_ready = 1'b1; in_valid = 1'b1;
      #1;
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk_out("release", 1'b1, 64'hCAFE, 64'hF00D, 64'hF00D);

      // Drain: out_valid drops, data holds
      in_valid = 1'b0; read_data1 = 64'h1; read_data2 = 64'h2;
      step();
      chk_out("drain", 1'b0, 64'hCAFE, 64'hF00D, 64'hF00D);
      chk("drain_in_ready", {63'd0, in_ready}, 64'd1);

      // Reset mid-hold
      in_valid = 1'b1; read_data1 = 64'hD1; read_data2 = 64'hD2;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      chk_out("hold_pre_reset", 1'b1, 64'hD1, 64'hD2, 64'hD2);
      #2;
      reset = 1'b1;
      #1;
      chk_out("reset_mid_hold", 1'b0, 64'h0, 64'h0, 64'h0);
      chk("reset_mid_hold_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
